// File: rtl/amm_memory_slave.sv
// Avalon-MM slave memory: byte-enabled single-port storage with
// incrementing read and write bursts, one beat per cycle.
module amm_memory_slave #(
  parameter int A_W     = 8,
  parameter int D_W     = 64,
  parameter int BURST_W = 2,
  parameter int BE_EN   = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [A_W-1:0]     address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [D_W-1:0]     writedata_i,
  input  logic [D_W/8-1:0]   byteenable_i,
  input  logic [BURST_W-1:0] burstcount_i,
  output logic [D_W-1:0]     readdata_o,
  output logic               readdatavalid_o,
  output logic               waitrequest_o
);

  localparam int NB    = D_W / 8;
  localparam int DEPTH = 2 ** A_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } state_e;

  state_e             state_q, state_d;
  logic [A_W-1:0]     addr_q, addr_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [D_W-1:0]     rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;

  logic [D_W-1:0]     mem_q [DEPTH];

  logic               we;
  logic [A_W-1:0]     waddr;
  logic [NB-1:0]      be;
  logic [BURST_W-1:0] blen;

  // A zero burstcount is treated as a single beat
  assign blen = (burstcount_i == '0) ? BURST_W'(1) : burstcount_i;
  assign be   = (BE_EN != 0) ? byteenable_i : {NB{1'b1}};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    we       = 1'b0;
    waddr    = addr_q;
    unique case (state_q)
      IDLE: begin
        // Write has priority; a colliding read is dropped
        if (write_i) begin
          we     = 1'b1;
          waddr  = address_i;
          addr_d = address_i + A_W'(1);
          cnt_d  = blen - BURST_W'(1);
          if (blen != BURST_W'(1)) state_d = WRITE;
        end else if (read_i) begin
          addr_d  = address_i;
          cnt_d   = blen;
          state_d = READ;
        end
      end
      WRITE: begin
        if (write_i) begin
          we     = 1'b1;
          addr_d = addr_q + A_W'(1);
          cnt_d  = cnt_q - BURST_W'(1);
          if (cnt_q == BURST_W'(1)) state_d = IDLE;
        end
      end
      READ: begin
        rdata_d  = mem_q[addr_q];
        rvalid_d = 1'b1;
        addr_d   = addr_q + A_W'(1);
        cnt_d    = cnt_q - BURST_W'(1);
        if (cnt_q == BURST_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) we = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem_q[waddr][8*b +: 8] <= writedata_i[8*b +: 8];
      end
    end
  end

  assign readdata_o      = rdata_q;
  assign readdatavalid_o = rvalid_q;
  assign waitrequest_o   = rst_i | (state_q == READ);

endmodule

// File: tb/tb_amm_memory_slave.sv
// Bench for amm_memory_slave: reference memory model plus a
// scoreboard queue of expected read beats checked on readdatavalid.
module tb_amm_memory_slave;

  logic        clk;
  logic        rst;
  logic [7:0]  address;
  logic        read;
  logic        write;
  logic [63:0] writedata;
  logic [7:0]  byteenable;
  logic [1:0]  burstcount;
  logic [63:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] model [256];
  logic [63:0] exp_q [$];

  amm_memory_slave #(
    .A_W(8), .D_W(64), .BURST_W(2), .BE_EN(1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .address_i(address),
    .read_i(read),
    .write_i(write),
    .writedata_i(writedata),
    .byteenable_i(byteenable),
    .burstcount_i(burstcount),
    .readdata_o(readdata),
    .readdatavalid_o(readdatavalid),
    .waitrequest_o(waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (readdatavalid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_beat: got valid data %h, required no beat",
                 readdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (readdata !== e) begin
          n_bad++;
          $display("FAIL read_data: got %h, required %h", readdata, e);
        end
      end
    end
  end

  function automatic void mwr(input logic [7:0] a, input logic [63:0] d,
                              input logic [7:0] be);
    for (int b = 0; b < 8; b++)
      if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
  endfunction

  task automatic accept(output bit ok);
    int n = 0;
    while (waitrequest !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 20);
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: waitrequest=%b, required 0", waitrequest);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [63:0] d,
                    input logic [7:0] be);
    bit ok;
    @(negedge clk);
    address = a; writedata = d; byteenable = be;
    burstcount = 2'd1; write = 1'b1;
    accept(ok);
    write = 1'b0;
    if (ok) mwr(a, d, be);
  endtask

  task automatic rd(input logic [7:0] a, input logic [1:0] n);
    bit ok;
    int nb;
    nb = (n == 0) ? 1 : int'(n);
    @(negedge clk);
    address = a; burstcount = n; read = 1'b1;
    accept(ok);
    read = 1'b0;
    if (ok) begin
      for (int i = 0; i < nb; i++) exp_q.push_back(model[a + 8'(i)]);
      @(negedge clk);
      n_cmp++;
      if (readdatavalid !== 1'b0) begin
        n_bad++;
        $display("FAIL rd_lat_early: valid=%b, required 0", readdatavalid);
      end
      @(negedge clk);
      n_cmp++;
      if (readdatavalid !== 1'b1) begin
        n_bad++;
        $display("FAIL rd_lat_first: valid=%b, required 1", readdatavalid);
      end
      drain();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (waitrequest !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_wait: got %b, required 1", waitrequest);
    end
    n_cmp++;
    if (readdatavalid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_valid: got %b, required 0", readdatavalid);
    end
    n_cmp++;
    if (readdata !== 64'h0) begin
      n_bad++;
      $display("FAIL rst_data: got %h, required 0", readdata);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (waitrequest !== 1'b0) begin
      n_bad++;
      $display("FAIL post_rst_wait: got %b, required 0", waitrequest);
    end
  endtask

  task automatic test_single();
    wr(8'h5A, 64'h0123456789ABCDEF, 8'hFF);
    rd(8'h5A, 2'd1);
    for (int i = 0; i < 10; i++) begin
      logic [7:0]  a;
      logic [63:0] d;
      a = 8'($urandom_range(0, 255));
      d = {32'($urandom), 32'($urandom)};
      wr(a, d, 8'hFF);
      rd(a, 2'd1);
    end
  endtask

  task automatic test_byteen();
    wr(8'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wr(8'h10, 64'h0, 8'h0F);
    rd(8'h10, 2'd1);
  endtask

  task automatic test_wburst_wrap();
    bit ok;
    @(negedge clk);
    address = 8'hFF; burstcount = 2'd3; byteenable = 8'hFF;
    writedata = 64'hAAAA_0000_0000_000A; write = 1'b1;
    accept(ok);
    if (ok) mwr(8'hFF, writedata, 8'hFF);
    write = 1'b0; address = 8'h55; burstcount = 2'd1;
    @(negedge clk);
    n_cmp++;
    if (waitrequest !== 1'b0) begin
      n_bad++;
      $display("FAIL wburst_wait: got %b, required 0", waitrequest);
    end
    writedata = 64'hBBBB_0000_0000_000B; write = 1'b1;
    accept(ok);
    if (ok) mwr(8'h00, writedata, 8'hFF);
    writedata = 64'hCCCC_0000_0000_000C; burstcount = 2'd0;
    accept(ok);
    if (ok) mwr(8'h01, writedata, 8'hFF);
    write = 1'b0;
    rd(8'hFF, 2'd1);
    rd(8'h00, 2'd1);
    rd(8'h01, 2'd1);
  endtask

  task automatic test_read_burst();
    bit ok;
    @(negedge clk);
    address = 8'hFF; burstcount = 2'd3; read = 1'b1;
    accept(ok);
    read = 1'b0;
    exp_q.push_back(model[8'hFF]);
    exp_q.push_back(model[8'h00]);
    exp_q.push_back(model[8'h01]);
    address = 8'h20; writedata = 64'hFEED_FACE_CAFE_BEEF;
    byteenable = 8'hFF; burstcount = 2'd1; write = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (waitrequest !== (i <= 3)) begin
        n_bad++;
        $display("FAIL rburst_wait[%0d]: got %b, required %b",
                 i, waitrequest, i <= 3);
      end
      n_cmp++;
      if (readdatavalid !== (i >= 2)) begin
        n_bad++;
        $display("FAIL rburst_valid[%0d]: got %b, required %b",
                 i, readdatavalid, i >= 2);
      end
    end
    accept(ok);
    write = 1'b0;
    if (ok) mwr(8'h20, 64'hFEED_FACE_CAFE_BEEF, 8'hFF);
    drain();
    rd(8'h20, 2'd1);
  endtask

  task automatic test_collision();
    bit ok;
    @(negedge clk);
    address = 8'h30; writedata = 64'h1122_3344_5566_7788;
    byteenable = 8'hFF; burstcount = 2'd1;
    write = 1'b1; read = 1'b1;
    accept(ok);
    write = 1'b0; read = 1'b0;
    if (ok) mwr(8'h30, 64'h1122_3344_5566_7788, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (readdatavalid !== 1'b0) begin
        n_bad++;
        $display("FAIL collide_valid[%0d]: got %b, required 0",
                 i, readdatavalid);
      end
    end
    rd(8'h30, 2'd1);
  endtask

  task automatic test_reset_abort();
    bit ok;
    wr(8'h40, 64'h4040_4040_4040_4040, 8'hFF);
    wr(8'h41, 64'h4141_4141_4141_4141, 8'hFF);
    wr(8'h42, 64'h4242_4242_4242_4242, 8'hFF);
    @(negedge clk);
    address = 8'h40; burstcount = 2'd3; read = 1'b1;
    accept(ok);
    read = 1'b0;
    exp_q.push_back(model[8'h40]);
    exp_q.push_back(model[8'h41]);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (readdatavalid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_valid: got %b, required 0", readdatavalid);
    end
    n_cmp++;
    if (readdata !== 64'h0) begin
      n_bad++;
      $display("FAIL abort_data: got %h, required 0", readdata);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL abort_beats: %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (waitrequest !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle: waitrequest=%b, required 0", waitrequest);
    end
    rd(8'h42, 2'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = 64'h0;
    rst = 1'b1; address = '0; read = 1'b0; write = 1'b0;
    writedata = '0; byteenable = '0; burstcount = 2'd1;
    test_reset();
    test_single();
    test_byteen();
    test_wburst_wrap();
    test_read_burst();
    test_collision();
    test_reset_abort();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
